// File: rtl/sdp_rdma_unpack_ng_pkg.sv
// Shared SDP unpacker package.
// Holds the unpacker state encoding and small mask helpers used by the
// read-DMA unpacker. Helpers operate on a fixed 32-bit mask container, so
// atom counts up to 32 per beat/word are supported.
package sdp_rdma_unpack_ng_pkg;

  localparam int unsigned UNPK_MAX_ATOMS = 32;

  // Unpacker FSM encoding.
  localparam logic [0:0] UNPK_ACC   = 1'b0;
  localparam logic [0:0] UNPK_FLUSH = 1'b1;

  // Number of set bits in m.
  function automatic int unsigned popcount(input logic [UNPK_MAX_ATOMS-1:0] m);
    int unsigned n;
    n = 0;
    for (int i = 0; i < UNPK_MAX_ATOMS; i++) begin
      n = n + {31'd0, m[i]};
    end
    return n;
  endfunction

  // True when the set bits of m form one run starting at bit 0 (or m == 0).
  // Adding one to such a run carries out of every set bit.
  function automatic logic mask_is_contig(input logic [UNPK_MAX_ATOMS-1:0] m);
    logic [UNPK_MAX_ATOMS-1:0] m_inc;
    m_inc = m + 1'b1;
    return (m & m_inc) == '0;
  endfunction

  // n low ones.
  function automatic logic [UNPK_MAX_ATOMS-1:0] mask_from_cnt(input int unsigned n);
    logic [UNPK_MAX_ATOMS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < UNPK_MAX_ATOMS; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/sdp_unpack_skid2.sv
// Two-entry valid/ready FIFO used as the unpacker output register.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   in_vld/in_rdy      push side; in_rdy depends only on registered occupancy
//   in_data [W]        pushed entry
//   out_vld/out_rdy    pop side; out_data is the head entry
//   out_data [W]       head entry, held until popped
// Push and pop may happen in the same cycle.
module sdp_unpack_skid2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_data
);

  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] ent0_q, ent0_d;
  logic [W-1:0] ent1_q, ent1_d;
  logic         pop, push;
  logic [1:0]   cnt_after_pop;

  assign in_rdy   = (cnt_q != 2'd2);
  assign out_vld  = (cnt_q != 2'd0);
  assign out_data = ent0_q;

  // ent0 is always the head; a pop shifts ent1 down, and a push lands in the
  // first slot that is free after that shift.
  always_comb begin
    pop           = out_vld & out_rdy;
    push          = in_vld & in_rdy;
    ent0_d        = ent0_q;
    ent1_d        = ent1_q;
    if (pop) ent0_d = ent1_q;
    cnt_after_pop = cnt_q - {1'b0, pop};
    if (push) begin
      if (cnt_after_pop == 2'd0) ent0_d = in_data;
      else                       ent1_d = in_data;
    end
    cnt_d = cnt_after_pop + {1'b0, push};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 2'd0;
      ent0_q <= '0;
      ent1_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
    end
  end

endmodule

// File: rtl/sdp_rdma_unpack_ng.sv
// SDP read-DMA unpacker: packs masked read-return beats of IN_ATOMS atoms into
// words of OUT_ATOMS atoms, with spill into the next word and explicit
// end-of-frame. Output is registered through a 2-entry FIFO.
// Ports:
//   nvdla_core_clk / nvdla_core_rstn   clock, async active-low reset
//   inp_pvld/inp_prdy, inp_data, inp_mask, inp_end   input beats
//   out_pvld/out_prdy, out_data, out_mask, out_end   packed words
//   err_mask                                         sticky non-contiguous mask flag
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high; a producer holds valid and its payload until that edge, and
// ready never depends combinationally on the same interface's valid.
module sdp_rdma_unpack_ng
  import sdp_rdma_unpack_ng_pkg::*;
#(
  parameter int ATOM_W    = 64,
  parameter int IN_ATOMS  = 1,
  parameter int OUT_ATOMS = 4
) (
  input  logic                        nvdla_core_clk,
  input  logic                        nvdla_core_rstn,
  input  logic                        inp_pvld,
  output logic                        inp_prdy,
  input  logic [IN_ATOMS*ATOM_W-1:0]  inp_data,
  input  logic [IN_ATOMS-1:0]         inp_mask,
  input  logic                        inp_end,
  output logic                        out_pvld,
  input  logic                        out_prdy,
  output logic [OUT_ATOMS*ATOM_W-1:0] out_data,
  output logic [OUT_ATOMS-1:0]        out_mask,
  output logic                        out_end,
  output logic                        err_mask
);

  localparam int CNT_W  = $clog2(OUT_ATOMS + 1);
  localparam int SUM_W  = CNT_W + 1;
  localparam int SIZE_W = $clog2(IN_ATOMS + 1);
  localparam int WORD_W = OUT_ATOMS * ATOM_W;
  localparam int FIFO_W = 1 + OUT_ATOMS + WORD_W;
  localparam logic [SUM_W-1:0] OUT_N = SUM_W'(OUT_ATOMS);

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  pack_cnt_q, pack_cnt_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic              err_q, err_d;

  logic [SIZE_W-1:0]    size;
  logic [SUM_W-1:0]     sum;
  logic                 mask_contig;
  logic                 inp_accept;
  logic                 fifo_in_rdy;
  logic [WORD_W-1:0]    word_data;
  logic [WORD_W-1:0]    acc_next;
  int                   slot;
  logic                 push_vld;
  logic                 push_end;
  logic [OUT_ATOMS-1:0] push_mask;
  logic [WORD_W-1:0]    push_data;

  assign size        = SIZE_W'(popcount(UNPK_MAX_ATOMS'(inp_mask)));
  assign sum         = SUM_W'(pack_cnt_q) + SUM_W'(size);
  assign mask_contig = mask_is_contig(UNPK_MAX_ATOMS'(inp_mask));
  assign inp_prdy    = (state_q == UNPK_ACC) & fifo_in_rdy;
  assign inp_accept  = inp_pvld & inp_prdy;
  assign err_mask    = err_q;

  // Atom placement. Set mask bits are taken in ascending order, so a
  // non-contiguous mask still yields popcount atoms. word_data is the word
  // that would be emitted now (atoms that fit before the wrap); acc_next also
  // carries the atoms that wrapped into slots 0.. of the following word.
  // Wrapped slots are always below pack_cnt, so they never collide with the
  // atoms just placed in this beat.
  always_comb begin
    word_data = acc_q;
    acc_next  = acc_q;
    slot      = int'(pack_cnt_q);
    for (int k = 0; k < IN_ATOMS; k++) begin
      if (inp_mask[k]) begin
        if (slot < OUT_ATOMS) begin
          word_data[slot*ATOM_W +: ATOM_W] = inp_data[k*ATOM_W +: ATOM_W];
          acc_next[slot*ATOM_W +: ATOM_W]  = inp_data[k*ATOM_W +: ATOM_W];
        end else begin
          acc_next[(slot-OUT_ATOMS)*ATOM_W +: ATOM_W] = inp_data[k*ATOM_W +: ATOM_W];
        end
        slot = slot + 1;
      end
    end
  end

  // Pack/emit control. Pushes in ACC only happen on an accepted beat, which
  // already implies FIFO space. In FLUSH, pack_cnt holds the spill count.
  always_comb begin
    state_d    = state_q;
    pack_cnt_d = pack_cnt_q;
    acc_d      = acc_q;
    err_d      = err_q;
    push_vld   = 1'b0;
    push_end   = 1'b0;
    push_mask  = '0;
    push_data  = word_data;
    if (state_q == UNPK_ACC) begin
      if (inp_accept) begin
        acc_d = acc_next;
        if (!mask_contig) err_d = 1'b1;
        if (sum < OUT_N) begin
          pack_cnt_d = inp_end ? '0 : CNT_W'(sum);
          if (inp_end && (sum != '0)) begin
            push_vld  = 1'b1;
            push_end  = 1'b1;
            push_mask = OUT_ATOMS'(mask_from_cnt(32'(sum)));
          end
        end else begin
          push_vld  = 1'b1;
          push_mask = '1;
          if (sum == OUT_N) begin
            push_end   = inp_end;
            pack_cnt_d = '0;
          end else begin
            // Full word goes out now; the spill word follows, either with
            // later beats or on its own via FLUSH when the frame ends here.
            pack_cnt_d = CNT_W'(sum - OUT_N);
            if (inp_end) state_d = UNPK_FLUSH;
          end
        end
      end
    end else begin
      if (fifo_in_rdy) begin
        push_vld   = 1'b1;
        push_end   = 1'b1;
        push_data  = acc_q;
        push_mask  = OUT_ATOMS'(mask_from_cnt(32'(pack_cnt_q)));
        pack_cnt_d = '0;
        state_d    = UNPK_ACC;
      end
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q    <= UNPK_ACC;
      pack_cnt_q <= '0;
      acc_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pack_cnt_q <= pack_cnt_d;
      acc_q      <= acc_d;
      err_q      <= err_d;
    end
  end

  sdp_unpack_skid2 #(
    .W (FIFO_W)
  ) u_skid (
    .clk      (nvdla_core_clk),
    .rst_n    (nvdla_core_rstn),
    .in_vld   (push_vld),
    .in_rdy   (fifo_in_rdy),
    .in_data  ({push_end, push_mask, push_data}),
    .out_vld  (out_pvld),
    .out_rdy  (out_prdy),
    .out_data ({out_end, out_mask, out_data})
  );

endmodule

// File: tb/tb_sdp_rdma_unpack_ng.sv
module tb_sdp_rdma_unpack_ng;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rstn;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dut1: IN_ATOMS=1 (defaults), dut2: IN_ATOMS=2
  logic         in1_vld, in1_prdy, in1_end, ordy1, o1_vld, o1_end, err1;
  logic [63:0]  in1_data;
  logic [0:0]   in1_mask;
  logic [255:0] o1_data;
  logic [3:0]   o1_mask;

  logic         in2_vld, in2_prdy, in2_end, ordy2, o2_vld, o2_end, err2;
  logic [127:0] in2_data;
  logic [1:0]   in2_mask;
  logic [255:0] o2_data;
  logic [3:0]   o2_mask;

  sdp_rdma_unpack_ng #(.ATOM_W(64), .IN_ATOMS(1), .OUT_ATOMS(4)) dut1 (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .inp_pvld(in1_vld), .inp_prdy(in1_prdy), .inp_data(in1_data),
    .inp_mask(in1_mask), .inp_end(in1_end),
    .out_pvld(o1_vld), .out_prdy(ordy1), .out_data(o1_data),
    .out_mask(o1_mask), .out_end(o1_end), .err_mask(err1));

  sdp_rdma_unpack_ng #(.ATOM_W(64), .IN_ATOMS(2), .OUT_ATOMS(4)) dut2 (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .inp_pvld(in2_vld), .inp_prdy(in2_prdy), .inp_data(in2_data),
    .inp_mask(in2_mask), .inp_end(in2_end),
    .out_pvld(o2_vld), .out_prdy(ordy2), .out_data(o2_data),
    .out_mask(o2_mask), .out_end(o2_end), .err_mask(err2));

  // ---------------- bookkeeping ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [260:0] act, input logic [260:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic logic [63:0] at(input logic [15:0] t);
    return {t, 16'h5a5a, ~t, t ^ 16'h1234};
  endfunction

  function automatic logic [255:0] w4(input logic [63:0] s0, s1, s2, s3);
    return {s3, s2, s1, s0};
  endfunction

  function automatic logic [255:0] slot_bits(input logic [3:0] m);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) if (m[i]) r[i*64 +: 64] = '1;
    return r;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    bit          sel;      // 0 = dut1, 1 = dut2
    bit          vld;
    logic [1:0]  msk;
    logic [63:0] a0, a1;
    bit          eof;
    bit          x_iprdy, x_ovld;
    logic [3:0]  x_omask;
    bit          x_oend, x_err;
    logic [255:0] x_odata;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit sel, input bit vld, input logic [1:0] msk,
                              input logic [63:0] a0, input logic [63:0] a1, input bit eof,
                              input bit xi, input bit xv, input logic [3:0] xm,
                              input bit xe, input bit xerr, input logic [255:0] xd);
    vec_t v;
    v.sel = sel; v.vld = vld; v.msk = msk; v.a0 = a0; v.a1 = a1; v.eof = eof;
    v.x_iprdy = xi; v.x_ovld = xv; v.x_omask = xm; v.x_oend = xe;
    v.x_err = xerr; v.x_odata = xd;
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  logic [260:0] exp_q[$];
  bit           mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en && o1_vld && ordy1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected word", {o1_end, o1_mask, o1_data}, '0);
      end else begin
        chk("drain word", {o1_end, o1_mask, o1_data}, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    in1_vld = 1'b0; in1_data = '0; in1_mask = '0; in1_end = 1'b0;
    in2_vld = 1'b0; in2_data = '0; in2_mask = '0; in2_end = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic drive1(input logic [63:0] d, input bit eof);
    int waited;
    waited = 0;
    in1_vld = 1'b1; in1_data = d; in1_mask = 1'b1; in1_end = eof;
    while (!in1_prdy && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in1_prdy) begin
      n_total++;
      $display("FAIL drive1 timeout: inp_prdy stayed 0 for %0d cycles", waited);
    end
    @(posedge clk); #1;
    in1_vld = 1'b0; in1_end = 1'b0;
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL %s: %0d words left, want 0", nm, exp_q.size());
    repeat (3) begin @(posedge clk); #1; end
    mon_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  logic [63:0] d4[12];

  initial begin
    logic         a_iprdy, a_ovld, a_oend, a_err;
    logic [3:0]   a_omask;
    logic [255:0] a_data;

    // Test 1: four single-atom beats, end on the last
    tbl.push_back(mk(0,1,2'b01,at(16'hA0),'0,0, 1,0,4'h0,0,0,'0));
    tbl.push_back(mk(0,1,2'b01,at(16'hA1),'0,0, 1,0,4'h0,0,0,'0));
    tbl.push_back(mk(0,1,2'b01,at(16'hA2),'0,0, 1,0,4'h0,0,0,'0));
    tbl.push_back(mk(0,1,2'b01,at(16'hA3),'0,1, 1,0,4'h0,0,0,'0));
    tbl.push_back(mk(0,0,2'b00,'0,'0,0, 1,1,4'hf,1,0,w4(at(16'hA0),at(16'hA1),at(16'hA2),at(16'hA3))));
    // Test 2: three beats with end, then empty end beat
    tbl.push_back(mk(0,1,2'b01,at(16'hC0),'0,0, 1,0,4'h0,0,0,'0));
    tbl.push_back(mk(0,1,2'b01,at(16'hC1),'0,0, 1,0,4'h0,0,0,'0));
    tbl.push_back(mk(0,1,2'b01,at(16'hC2),'0,1, 1,0,4'h0,0,0,'0));
    tbl.push_back(mk(0,1,2'b00,'0,'0,1, 1,1,4'h7,1,0,w4(at(16'hC0),at(16'hC1),at(16'hC2),'0)));
    tbl.push_back(mk(0,0,2'b00,'0,'0,0, 1,0,4'h0,0,0,'0));
    tbl.push_back(mk(0,0,2'b00,'0,'0,0, 1,0,4'h0,0,0,'0));
    // Test 3: IN_ATOMS=2 spill with end -> FLUSH, one bubble
    tbl.push_back(mk(1,1,2'b01,at(16'hB0),'0,0, 1,0,4'h0,0,0,'0));
    tbl.push_back(mk(1,1,2'b11,at(16'hB1),at(16'hB2),0, 1,0,4'h0,0,0,'0));
    tbl.push_back(mk(1,1,2'b11,at(16'hB3),at(16'hB4),1, 1,0,4'h0,0,0,'0));
    tbl.push_back(mk(1,0,2'b00,'0,'0,0, 0,1,4'hf,0,0,w4(at(16'hB0),at(16'hB1),at(16'hB2),at(16'hB3))));
    tbl.push_back(mk(1,0,2'b00,'0,'0,0, 1,1,4'h1,1,0,w4(at(16'hB4),'0,'0,'0)));
    tbl.push_back(mk(1,0,2'b00,'0,'0,0, 1,0,4'h0,0,0,'0));
    // Test 5: non-contiguous mask 2'b10
    tbl.push_back(mk(1,1,2'b10,at(16'hE0),at(16'hE1),0, 1,0,4'h0,0,0,'0));
    tbl.push_back(mk(1,1,2'b11,at(16'hF0),at(16'hF1),0, 1,0,4'h0,0,1,'0));
    tbl.push_back(mk(1,1,2'b01,at(16'hF2),'0,1, 1,0,4'h0,0,1,'0));
    tbl.push_back(mk(1,0,2'b00,'0,'0,0, 1,1,4'hf,1,1,w4(at(16'hE1),at(16'hF0),at(16'hF1),at(16'hF2))));
    tbl.push_back(mk(1,0,2'b00,'0,'0,0, 1,0,4'h0,0,1,'0));
    // Spill without end carries into the next word
    tbl.push_back(mk(1,1,2'b01,at(16'h60),'0,0, 1,0,4'h0,0,1,'0));
    tbl.push_back(mk(1,1,2'b11,at(16'h61),at(16'h62),0, 1,0,4'h0,0,1,'0));
    tbl.push_back(mk(1,1,2'b11,at(16'h63),at(16'h64),0, 1,0,4'h0,0,1,'0));
    tbl.push_back(mk(1,1,2'b11,at(16'h65),at(16'h66),1, 1,1,4'hf,0,1,w4(at(16'h60),at(16'h61),at(16'h62),at(16'h63))));
    tbl.push_back(mk(1,0,2'b00,'0,'0,0, 1,1,4'h7,1,1,w4(at(16'h64),at(16'h65),at(16'h66),'0)));
    tbl.push_back(mk(1,0,2'b00,'0,'0,0, 1,0,4'h0,0,1,'0));

    // Reset
    rstn = 1'b0; ordy1 = 1'b1; ordy2 = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst out_pvld", o1_vld, 1'b0);
    chk("rst out_mask", o1_mask, 4'h0);
    chk("rst out_end", o1_end, 1'b0);
    chk("rst out_data", o1_data, '0);
    chk("rst err_mask", err1, 1'b0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("rst inp_prdy dut1", in1_prdy, 1'b1);
    chk("rst inp_prdy dut2", in2_prdy, 1'b1);

    // Table: inputs applied at posedge+1, outputs checked at the negedge
    // (they reflect all earlier rows).
    foreach (tbl[i]) begin
      @(posedge clk); #1;
      idle_inputs();
      if (tbl[i].sel == 1'b0) begin
        in1_vld = tbl[i].vld; in1_mask = tbl[i].msk[0]; in1_data = tbl[i].a0; in1_end = tbl[i].eof;
      end else begin
        in2_vld = tbl[i].vld; in2_mask = tbl[i].msk; in2_data = {tbl[i].a1, tbl[i].a0}; in2_end = tbl[i].eof;
      end
      @(negedge clk);
      if (tbl[i].sel == 1'b0) begin
        a_iprdy = in1_prdy; a_ovld = o1_vld; a_omask = o1_mask; a_oend = o1_end; a_data = o1_data; a_err = err1;
      end else begin
        a_iprdy = in2_prdy; a_ovld = o2_vld; a_omask = o2_mask; a_oend = o2_end; a_data = o2_data; a_err = err2;
      end
      chk($sformatf("row%0d inp_prdy", i), a_iprdy, tbl[i].x_iprdy);
      chk($sformatf("row%0d out_pvld", i), a_ovld, tbl[i].x_ovld);
      chk($sformatf("row%0d err_mask", i), a_err, tbl[i].x_err);
      if (tbl[i].x_ovld) begin
        chk($sformatf("row%0d out_mask", i), a_omask, tbl[i].x_omask);
        chk($sformatf("row%0d out_end", i), a_oend, tbl[i].x_oend);
        chk($sformatf("row%0d out_data", i), a_data & slot_bits(tbl[i].x_omask),
            tbl[i].x_odata & slot_bits(tbl[i].x_omask));
      end
    end
    @(posedge clk); #1;
    idle_inputs();

    // Test 4: backpressure with three full words offered
    for (int b = 0; b < 12; b++) d4[b] = at(16'h0D00 + 16'(b));
    exp_q.push_back({1'b0, 4'hf, w4(d4[0], d4[1], d4[2], d4[3])});
    exp_q.push_back({1'b0, 4'hf, w4(d4[4], d4[5], d4[6], d4[7])});
    exp_q.push_back({1'b1, 4'hf, w4(d4[8], d4[9], d4[10], d4[11])});
    ordy1 = 1'b0;
    for (int b = 0; b < 8; b++) drive1(d4[b], 1'b0);
    in1_vld = 1'b1; in1_data = d4[8]; in1_mask = 1'b1; in1_end = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d inp_prdy", c), in1_prdy, 1'b0);
      chk($sformatf("bp%0d out_pvld", c), o1_vld, 1'b1);
      chk($sformatf("bp%0d head", c), {o1_end, o1_mask, o1_data}, exp_q[0]);
      @(posedge clk); #1;
    end
    ordy1 = 1'b1;
    mon_en = 1'b1;
    for (int b = 8; b < 12; b++) drive1(d4[b], b == 11);
    wait_drain("bp drain", 50);

    // Test 6: reset mid-frame with pack_cnt = 2
    drive1(at(16'h0C60), 1'b0);
    drive1(at(16'h0C61), 1'b0);
    rstn = 1'b0;
    @(negedge clk);
    chk("mid rst out_pvld", o1_vld, 1'b0);
    chk("mid rst out_mask", o1_mask, 4'h0);
    chk("mid rst out_end", o1_end, 1'b0);
    chk("mid rst out_data", o1_data, '0);
    chk("mid rst err_mask dut2", err2, 1'b0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    chk("post rst inp_prdy", in1_prdy, 1'b1);
    @(posedge clk); #1;
    exp_q.push_back({1'b1, 4'hf, w4(at(16'h0110), at(16'h0111), at(16'h0112), at(16'h0113))});
    mon_en = 1'b1;
    drive1(at(16'h0110), 1'b0);
    drive1(at(16'h0111), 1'b0);
    drive1(at(16'h0112), 1'b0);
    drive1(at(16'h0113), 1'b1);
    wait_drain("post rst drain", 20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
